// File: rtl/msx_pkg.sv
// Shared definitions for the MSX host cycle sequencer: register map, control byte, request and state types.
// Latency: none, constants and types only.
// Backpressure: not applicable.
package msx_pkg;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_AHI  = 2'd1;
    localparam logic [1:0] REG_ALO  = 2'd2;
    localparam logic [1:0] REG_DAT  = 2'd3;
    localparam logic [1:0] REG_STAT = 2'd0;
    localparam logic [1:0] REG_BUS  = 2'd1;

    localparam int STAT_NWAIT = 0;
    localparam int STAT_INT   = 1;

    localparam int CTL_RD    = 7;
    localparam int CTL_WR    = 6;
    localparam int CTL_IORQ  = 5;
    localparam int CTL_MERQ  = 4;
    localparam int CTL_SLTSL = 3;
    localparam int CTL_RESET = 2;

    localparam logic [7:0] CTL_MEM_WR  = 8'((1 << CTL_WR) | (1 << CTL_MERQ) | (1 << CTL_SLTSL));
    localparam logic [7:0] CTL_MEM_RD  = 8'((1 << CTL_RD) | (1 << CTL_MERQ) | (1 << CTL_SLTSL));
    localparam logic [7:0] CTL_IO_WR   = 8'((1 << CTL_WR) | (1 << CTL_IORQ));
    localparam logic [7:0] CTL_IO_RD   = 8'((1 << CTL_RD) | (1 << CTL_IORQ));
    localparam logic [7:0] CTL_BUS_RST = 8'(1 << CTL_RESET);
    localparam logic [7:0] CTL_RELEASE = 8'h00;

    localparam logic [1:0] KIND_MEM = 2'd0;
    localparam logic [1:0] KIND_IO  = 2'd1;
    localparam logic [1:0] KIND_RST = 2'd2;
    localparam logic [1:0] KIND_RSV = 2'd3;

    typedef enum logic [3:0] {
        ST_INIT, ST_IDLE, ST_AHI, ST_ALO, ST_DAT, ST_CTRL,
        ST_HOLD, ST_POLL, ST_RDATA, ST_REL, ST_RESP
    } state_e;

    typedef enum logic [1:0] {PH_SETUP, PH_LOW, PH_HIGH} phase_e;

    typedef struct packed {
        logic [1:0]  kind;
        logic        write;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;

    function automatic logic kind_is_reset(input logic [1:0] kind);
        return (kind == KIND_RST) || (kind == KIND_RSV);
    endfunction

    function automatic logic [7:0] ctrl_byte(input logic [1:0] kind, input logic write);
        logic [7:0] b;
        case (kind)
            KIND_MEM: b = write ? CTL_MEM_WR : CTL_MEM_RD;
            KIND_IO:  b = write ? CTL_IO_WR : CTL_IO_RD;
            default:  b = CTL_BUS_RST;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/msx_port_strobe.sv
// Performs one register access on the msxbus parallel port: setup, low, high phases of STB_CYC clocks each.
// Latency: 3*STB_CYC clocks from start; done pulses on the final clock, when rdata carries mdata_in.
// Backpressure: none; start on the done cycle chains the next access with no idle gap.
module msx_port_strobe
    import msx_pkg::*;
#(
    parameter int STB_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       is_write,
    input  logic [1:0] acc_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       mcs,
    output logic       mw,
    output logic       mclk,
    output logic [1:0] maddr,
    output logic [7:0] mdata_out,
    output logic       mdata_oe,
    input  logic [7:0] mdata_in
);

    localparam int CW = (STB_CYC > 1) ? $clog2(STB_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STB_CYC - 1);

    phase_e     phase;
    logic [CW-1:0] cnt;
    logic       wr_q;
    logic [1:0] addr_q;
    logic [7:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            phase  <= PH_SETUP;
            cnt    <= '0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            phase  <= PH_SETUP;
            cnt    <= '0;
            wr_q   <= is_write;
            addr_q <= acc_addr;
            data_q <= wdata;
        end else if (busy) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                if (phase == PH_HIGH) busy  <= 1'b0;
                else                  phase <= (phase == PH_SETUP) ? PH_LOW : PH_HIGH;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign done  = busy && (phase == PH_HIGH) && (cnt == CNT_LAST);
    assign rdata = done ? mdata_in : 8'h00;

    // Pins fall back to their idle levels whenever no access is in progress.
    assign mcs       = ~busy;
    assign mclk      = ~(busy && (phase == PH_LOW));
    assign mw        = busy ? ~wr_q : 1'b1;
    assign maddr     = busy ? addr_q : 2'd0;
    assign mdata_oe  = busy && wr_q;
    assign mdata_out = (busy && wr_q) ? data_q : 8'h00;

endmodule

// File: rtl/msx_cycle_seq.sv
// Turns one MSX bus request into ordered msxbus register accesses and returns data/status.
// Latency: 41 clocks accept-to-response at defaults with nwait ready; +6 per extra poll.
// Backpressure: req_ready only in IDLE (one transaction in flight); response held until rsp_ready.
module msx_cycle_seq
    import msx_pkg::*;
#(
    parameter int STB_CYC  = 2,
    parameter int HOLD_CYC = 4,
    parameter int RST_CYC  = 64,
    parameter int WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_kind,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_rdata,
    output logic [1:0]  rsp_status,
    output logic        mcs,
    output logic        mw,
    output logic        mclk,
    output logic [1:0]  maddr,
    output logic [7:0]  mdata_out,
    output logic        mdata_oe,
    input  logic [7:0]  mdata_in
);

    state_e      state, state_nxt;
    req_t        req_q, cur;
    logic        launch, accept, hold_last, poll_last, nwait;
    logic        acc_wr;
    logic [1:0]  acc_addr;
    logic [7:0]  acc_data;
    logic        stb_busy, stb_done;
    logic [7:0]  stb_rdata;
    logic [15:0] hold_cnt;
    logic [7:0]  poll_cnt;
    logic [7:0]  rdata_q;
    logic [1:0]  status_q;

    // In IDLE the first access launches in the accept cycle, before req_q is loaded.
    assign cur       = (state == ST_IDLE) ? req_t'{req_kind, req_write, req_addr, req_wdata} : req_q;
    assign accept    = (state == ST_IDLE) && req_valid;
    assign nwait     = stb_rdata[STAT_NWAIT];
    assign poll_last = (poll_cnt == 8'(WAIT_MAX - 1));
    assign hold_last = (hold_cnt == (kind_is_reset(req_q.kind) ? 16'(RST_CYC - 1) : 16'(HOLD_CYC - 1)));

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            ST_INIT: begin
                if (stb_done)       state_nxt = ST_IDLE;
                else if (!stb_busy) launch    = 1'b1;
            end
            ST_IDLE: if (req_valid) begin
                launch    = 1'b1;
                state_nxt = kind_is_reset(cur.kind) ? ST_CTRL : ST_AHI;
            end
            ST_AHI: if (stb_done) begin
                launch    = 1'b1;
                state_nxt = ST_ALO;
            end
            ST_ALO: if (stb_done) begin
                launch    = 1'b1;
                state_nxt = cur.write ? ST_DAT : ST_CTRL;
            end
            ST_DAT: if (stb_done) begin
                launch    = 1'b1;
                state_nxt = ST_CTRL;
            end
            ST_CTRL: if (stb_done) state_nxt = ST_HOLD;
            ST_HOLD: if (hold_last) begin
                launch    = 1'b1;
                state_nxt = kind_is_reset(cur.kind) ? ST_REL : ST_POLL;
            end
            ST_POLL: if (stb_done) begin
                launch = 1'b1;
                if (nwait)          state_nxt = cur.write ? ST_REL : ST_RDATA;
                else if (poll_last) state_nxt = ST_REL;
                else                state_nxt = ST_POLL;
            end
            ST_RDATA: if (stb_done) begin
                launch    = 1'b1;
                state_nxt = ST_REL;
            end
            ST_REL:  if (stb_done)  state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_INIT;
        endcase
    end

    // Access parameters follow the state being entered; INIT and REL both write the release byte.
    always_comb begin
        acc_wr   = 1'b1;
        acc_addr = REG_CTRL;
        acc_data = CTL_RELEASE;
        case (state_nxt)
            ST_AHI:  begin acc_addr = REG_AHI; acc_data = cur.addr[15:8]; end
            ST_ALO:  begin acc_addr = REG_ALO; acc_data = cur.addr[7:0]; end
            ST_DAT:  begin acc_addr = REG_DAT; acc_data = cur.wdata; end
            ST_CTRL: acc_data = ctrl_byte(cur.kind, cur.write);
            ST_POLL: begin acc_wr = 1'b0; acc_addr = REG_STAT; acc_data = 8'h00; end
            ST_RDATA: begin acc_wr = 1'b0; acc_addr = REG_BUS; acc_data = 8'h00; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INIT;
            req_q    <= '0;
            hold_cnt <= '0;
            poll_cnt <= '0;
            rdata_q  <= '0;
            status_q <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= (state == ST_HOLD) ? hold_cnt + 16'd1 : 16'd0;
            if (accept) begin
                req_q    <= cur;
                poll_cnt <= '0;
                rdata_q  <= '0;
                status_q <= '0;
            end
            if (state == ST_POLL && stb_done) begin
                status_q[1] <= stb_rdata[STAT_INT];
                if (!nwait) begin
                    poll_cnt <= poll_cnt + 8'd1;
                    if (poll_last) status_q[0] <= 1'b1;
                end
            end
            if (state == ST_RDATA && stb_done) rdata_q <= stb_rdata;
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign rsp_valid  = (state == ST_RESP);
    assign rsp_rdata  = rsp_valid ? rdata_q : 8'h00;
    assign rsp_status = rsp_valid ? status_q : 2'b00;

    msx_port_strobe #(.STB_CYC(STB_CYC)) u_strobe (
        .clk       (clk),
        .rst       (rst),
        .start     (launch),
        .is_write  (acc_wr),
        .acc_addr  (acc_addr),
        .wdata     (acc_data),
        .busy      (stb_busy),
        .done      (stb_done),
        .rdata     (stb_rdata),
        .mcs       (mcs),
        .mw        (mw),
        .mclk      (mclk),
        .maddr     (maddr),
        .mdata_out (mdata_out),
        .mdata_oe  (mdata_oe),
        .mdata_in  (mdata_in)
    );

endmodule

// File: tb/tb_msx_cycle_seq.sv
// Directed bench for msx_cycle_seq with a small msxbus port model and falling-edge access log.
// Log entries are {oe, write, maddr, mdata_out}; reads log data 0.
module tb_msx_cycle_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_kind = 2'd0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [7:0]  req_wdata = 8'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_status;
    logic        mcs, mw, mclk, mdata_oe;
    logic [1:0]  maddr;
    logic [7:0]  mdata_out, mdata_in;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int polls = 0;
    int poll_base = 0;
    int zeros = 0;
    logic       irq_v = 1'b0;
    logic [7:0] bus_v = 8'h00;
    logic [11:0] evq[$];
    int          evc[$];

    msx_cycle_seq #(.STB_CYC(2), .HOLD_CYC(4), .RST_CYC(10), .WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_status(rsp_status),
        .mcs(mcs), .mw(mw), .mclk(mclk), .maddr(maddr),
        .mdata_out(mdata_out), .mdata_oe(mdata_oe), .mdata_in(mdata_in)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cyc++;

    // Status read reports nwait=0 for the first `zeros` polls of a transaction.
    assign mdata_in = (maddr == 2'd0) ? {6'b0, irq_v, ((polls - poll_base) > zeros)} : bus_v;

    always @(negedge mclk) begin
        if (mcs === 1'b0) begin
            evq.push_back({mdata_oe, ~mw, maddr, mdata_out});
            evc.push_back(cyc);
            if (mw === 1'b1 && maddr === 2'd0) polls++;
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic run_txn(input logic [1:0] kind, input logic wr, input logic [15:0] addr,
                           input logic [7:0] wd, input int zr, input logic [7:0] bv,
                           input logic iv, output int lat, output int eb);
        int n;
        @(negedge clk);
        zeros = zr; bus_v = bv; irq_v = iv; poll_base = polls; eb = evq.size();
        req_kind = kind; req_write = wr; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && n < 400) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        lat = n;
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
        end
    endtask

    task automatic ack_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        int eb;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({mcs, mclk, mw, maddr, mdata_out, mdata_oe} !== {3'b111, 2'd0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_pins: got mcs/mclk/mw=%b%b%b maddr=%0d mdata=%h oe=%b, required 111 0 00 0",
                     mcs, mclk, mw, maddr, mdata_out, mdata_oe);
        end
        n_checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_status} !== {2'b00, 8'h00, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_hs: got ready=%b valid=%b rdata=%h status=%b, required 0 0 00 00",
                     req_ready, rsp_valid, rsp_rdata, rsp_status);
        end
        eb = evq.size();
        rst = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        n_checks++;
        if (n !== 7) begin
            n_fail++;
            $display("FAIL reset_ready_cycle: got %0d, required 7", n);
        end
        n_checks++;
        if (evq.size() - eb !== 1) begin
            n_fail++;
            $display("FAIL reset_release_count: got %0d accesses, required 1", evq.size() - eb);
        end else begin
            n_checks++;
            if (evq[eb] !== 12'hC00) begin
                n_fail++;
                $display("FAIL reset_release: got %h, required c00", evq[eb]);
            end
        end
    endtask

    task automatic test_mem_write();
        int lat, eb;
        logic [11:0] exp[$];
        exp = '{12'hD41, 12'hE23, 12'hF5A, 12'hC58, 12'h000, 12'hC00};
        run_txn(2'd0, 1'b1, 16'h4123, 8'h5A, 0, 8'h00, 1'b0, lat, eb);
        n_checks++;
        if (lat !== 41) begin n_fail++; $display("FAIL wr_latency: got %0d, required 41", lat); end
        n_checks++;
        if ({rsp_rdata, rsp_status} !== 10'h000) begin
            n_fail++;
            $display("FAIL wr_rsp: got rdata=%h status=%b, required 00 00", rsp_rdata, rsp_status);
        end
        n_checks++;
        if (evq.size() - eb !== exp.size()) begin
            n_fail++;
            $display("FAIL wr_access_count: got %0d, required %0d", evq.size() - eb, exp.size());
        end
        for (int i = 0; i < exp.size() && eb + i < evq.size(); i++) begin
            n_checks++;
            if (evq[eb + i] !== exp[i]) begin
                n_fail++;
                $display("FAIL wr_access[%0d]: got %h, required %h", i, evq[eb + i], exp[i]);
            end
        end
        ack_rsp();
        n_checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL wr_return_idle: got ready=%b valid=%b, required 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_io_read();
        int lat, eb;
        logic [11:0] exp[$];
        exp = '{12'hD00, 12'hE98, 12'hCA0, 12'h000, 12'h100, 12'hC00};
        run_txn(2'd1, 1'b0, 16'h0098, 8'hEE, 0, 8'hC3, 1'b0, lat, eb);
        n_checks++;
        if (lat !== 41) begin n_fail++; $display("FAIL io_latency: got %0d, required 41", lat); end
        n_checks++;
        if ({rsp_rdata, rsp_status} !== {8'hC3, 2'b00}) begin
            n_fail++;
            $display("FAIL io_rsp: got rdata=%h status=%b, required c3 00", rsp_rdata, rsp_status);
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (eb + i >= evq.size() || evq[eb + i] !== exp[i]) begin
                n_fail++;
                $display("FAIL io_access[%0d]: got %h, required %h", i,
                         (eb + i < evq.size()) ? evq[eb + i] : 12'hxxx, exp[i]);
            end
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_rdata, rsp_status} !== {1'b1, 8'hC3, 2'b00}) begin
            n_fail++;
            $display("FAIL io_rsp_stable: got valid=%b rdata=%h status=%b, required 1 c3 00",
                     rsp_valid, rsp_rdata, rsp_status);
        end
        ack_rsp();
    endtask

    task automatic test_poll_wait();
        int lat, eb;
        logic [11:0] exp[$];
        exp = '{12'hD80, 12'hE01, 12'hC98, 12'h000, 12'h000, 12'h000, 12'h000, 12'h100, 12'hC00};
        run_txn(2'd0, 1'b0, 16'h8001, 8'h00, 3, 8'h3C, 1'b1, lat, eb);
        n_checks++;
        if (lat !== 59) begin n_fail++; $display("FAIL poll_latency: got %0d, required 59", lat); end
        n_checks++;
        if ({rsp_rdata, rsp_status} !== {8'h3C, 2'b10}) begin
            n_fail++;
            $display("FAIL poll_rsp: got rdata=%h status=%b, required 3c 10", rsp_rdata, rsp_status);
        end
        n_checks++;
        if (evq.size() - eb !== exp.size()) begin
            n_fail++;
            $display("FAIL poll_access_count: got %0d, required %0d", evq.size() - eb, exp.size());
        end
        for (int i = 0; i < exp.size() && eb + i < evq.size(); i++) begin
            n_checks++;
            if (evq[eb + i] !== exp[i]) begin
                n_fail++;
                $display("FAIL poll_access[%0d]: got %h, required %h", i, evq[eb + i], exp[i]);
            end
        end
        ack_rsp();
    endtask

    task automatic test_timeout();
        int lat, eb;
        logic [11:0] exp[$];
        exp = '{12'hD12, 12'hE34, 12'hC98, 12'h000, 12'h000, 12'h000, 12'h000, 12'hC00};
        run_txn(2'd0, 1'b0, 16'h1234, 8'h00, 100, 8'h77, 1'b0, lat, eb);
        n_checks++;
        if (lat !== 53) begin n_fail++; $display("FAIL to_latency: got %0d, required 53", lat); end
        n_checks++;
        if ({rsp_rdata, rsp_status} !== {8'h00, 2'b01}) begin
            n_fail++;
            $display("FAIL to_rsp: got rdata=%h status=%b, required 00 01", rsp_rdata, rsp_status);
        end
        n_checks++;
        if (evq.size() - eb !== exp.size()) begin
            n_fail++;
            $display("FAIL to_access_count: got %0d, required %0d", evq.size() - eb, exp.size());
        end
        for (int i = 0; i < exp.size() && eb + i < evq.size(); i++) begin
            n_checks++;
            if (evq[eb + i] !== exp[i]) begin
                n_fail++;
                $display("FAIL to_access[%0d]: got %h, required %h", i, evq[eb + i], exp[i]);
            end
        end
        ack_rsp();
    endtask

    task automatic test_bus_reset();
        int lat, eb;
        logic [1:0] kinds[2];
        kinds = '{2'd2, 2'd3};
        foreach (kinds[k]) begin
            run_txn(kinds[k], k[0], 16'hFFFF, 8'hAA, 0, 8'h55, 1'b1, lat, eb);
            n_checks++;
            if (lat !== 23) begin
                n_fail++;
                $display("FAIL busrst%0d_latency: got %0d, required 23", kinds[k], lat);
            end
            n_checks++;
            if ({rsp_rdata, rsp_status} !== 10'h000) begin
                n_fail++;
                $display("FAIL busrst%0d_rsp: got rdata=%h status=%b, required 00 00",
                         kinds[k], rsp_rdata, rsp_status);
            end
            n_checks++;
            if (evq.size() - eb !== 2) begin
                n_fail++;
                $display("FAIL busrst%0d_count: got %0d, required 2", kinds[k], evq.size() - eb);
            end else begin
                n_checks++;
                if ({evq[eb], evq[eb + 1]} !== {12'hC04, 12'hC00}) begin
                    n_fail++;
                    $display("FAIL busrst%0d_seq: got %h %h, required c04 c00", kinds[k], evq[eb], evq[eb + 1]);
                end
                n_checks++;
                if (evc[eb + 1] - evc[eb] !== 16) begin
                    n_fail++;
                    $display("FAIL busrst%0d_hold: got %0d cycles between strobes, required 16",
                             kinds[k], evc[eb + 1] - evc[eb]);
                end
            end
            ack_rsp();
        end
    endtask

    task automatic test_rst_mid();
        int n, eb, eb2;
        @(negedge clk);
        zeros = 0; poll_base = polls; eb = evq.size();
        req_kind = 2'd0; req_write = 1'b1; req_addr = 16'h7000; req_wdata = 8'h11; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_busy_ready: got %b, required 0", req_ready); end
        repeat (25) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({mcs, mclk, mw, maddr, mdata_oe, req_ready, rsp_valid} !== {3'b111, 2'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL mid_rst_pins: got mcs/mclk/mw=%b%b%b maddr=%0d oe=%b ready=%b valid=%b, required 111 0 0 0 0",
                     mcs, mclk, mw, maddr, mdata_oe, req_ready, rsp_valid);
        end
        n_checks++;
        if (evq.size() - eb !== 4 || evq[evq.size() - 1] !== 12'hC58) begin
            n_fail++;
            $display("FAIL mid_pre_hold: got %0d accesses last=%h, required 4 last=c58",
                     evq.size() - eb, evq[evq.size() - 1]);
        end
        eb2 = evq.size();
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        n_checks++;
        if (n !== 7) begin n_fail++; $display("FAIL mid_ready_cycle: got %0d, required 7", n); end
        n_checks++;
        if (evq.size() - eb2 !== 1 || evq[evq.size() - 1] !== 12'hC00) begin
            n_fail++;
            $display("FAIL mid_release: got %0d accesses last=%h, required 1 last=c00",
                     evq.size() - eb2, evq[evq.size() - 1]);
        end
    endtask

    initial begin
        test_reset();
        test_mem_write();
        test_io_read();
        test_poll_wait();
        test_timeout();
        test_bus_reset();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
